edit_field_sequencer: RTL and testbench
=======================================

EDIT_FIELD_SEQUENCER -- requirements
Module: edit_field_sequencer

Interface
REQ-001 Parameter NUM_FIELDS, default 6: number of editable 0-99 counter fields (sec, min, hour, day, month, year).
REQ-002 Parameter BLINK_DIV, default 25000000: clock cycles per half-period of the blink output.
REQ-003 Parameter TIMEOUT_CYC, default 500000000: idle cycles in EDIT before automatic abort.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 btn_edit, btn_next, btn_up, btn_down, btn_save  in  1 each  debounced button levels.
REQ-007 field_en  out  NUM_FIELDS  one-hot counter enable; bit i drives the EN input of field counter i.
REQ-008 up_o, down_o  out  1 each  single-cycle step commands, shared by all field counters.
REQ-009 field_sel  out  3  index of the field being edited.
REQ-010 edit_active  out  1  high while in EDIT.
REQ-011 blink  out  1  display blink gate for the selected field.
REQ-012 save_strobe, abort_strobe  out  1 each  single-cycle commit/discard notifications to the RTC write logic.

Function
REQ-013 Each button SHALL be rising-edge detected: an event exists at edge N when the level sampled at N is 1 and at N-1 was 0; held levels produce no further events.
REQ-014 FSM states SHALL be IDLE, EDIT, COMMIT; all outputs registered.
REQ-015 IDLE: edit_active=0, field_en=0, up_o=down_o=0, blink=0; edit event -> EDIT with field_sel=0; all other events ignored.
REQ-016 EDIT: edit_active=1, field_en = one-hot(field_sel).
REQ-017 EDIT event priority in one cycle SHALL be save > edit > next > up/down; lower-priority events in that cycle are dropped.
REQ-018 save event -> COMMIT; COMMIT asserts save_strobe for exactly one cycle, field_en=0, then -> IDLE.
REQ-019 edit event in EDIT -> IDLE with abort_strobe high for one cycle.
REQ-020 next event SHALL increment field_sel, wrapping NUM_FIELDS-1 -> 0.
REQ-021 up (down) event alone SHALL assert up_o (down_o) for exactly one cycle, on the cycle after the detecting edge, with field_en unchanged during that cycle.
REQ-022 up and down events in the same cycle SHALL both be dropped; up_o and down_o SHALL never be high together.
REQ-023 Timeout counter SHALL clear on entering EDIT and on any accepted event; at TIMEOUT_CYC-1 without an event -> IDLE with abort_strobe for one cycle.
REQ-024 blink SHALL be 1 on entering EDIT and after each field change, then toggle every BLINK_DIV cycles while in EDIT.
REQ-025 Counters (timeout, blink) SHALL saturate/wrap only within their own width sized by $clog2 of the parameter; no overflow side effects.

Reset
REQ-026 rst SHALL force IDLE, field_sel=0, field_en=0, all strobes/steps 0, blink=0, timers 0, and edge-detector history 0, from any state including mid-EDIT or COMMIT.
REQ-027 A button held high through reset release SHALL NOT generate an event.

Structure
REQ-028 A shared include file SHALL hold the state encodings, field index constants (FIELD_SEC=0 .. FIELD_YEAR=5) and NUM_FIELDS default.
REQ-029 One sub-module edge_pulse (clk, rst, level -> one-cycle pulse) SHALL be instanced once per button.

Verification (BLINK_DIV=4, TIMEOUT_CYC=20)
REQ-030 rst high 2 cycles, btn_edit pulse -> edit_active=1, field_sel=0, field_en=6'b000001, blink=1.
REQ-031 In EDIT, 6 btn_next pulses -> field_sel 1,2,3,4,5,0; field_en follows one-hot; blink restarts at 1 each change.
REQ-032 In EDIT field 2, btn_up held 10 cycles -> up_o high exactly one cycle with field_en=6'b000100; btn_up and btn_down rising same cycle -> no step.
REQ-033 btn_save and btn_next rising same cycle -> save_strobe one cycle, then IDLE, field_sel unchanged, field_en=0.
REQ-034 EDIT with no events 20 cycles -> abort_strobe one cycle, edit_active=0; rst asserted mid-EDIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/edit_field_sequencer_pkg.sv
// Shared types and constants for the RTC edit-field sequencer.
// States, field indices and default field count.
package edit_field_sequencer_pkg;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EDIT   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  localparam int NUM_FIELDS_DEF = 6;
  localparam int SEL_W          = 3;

  localparam int FIELD_SEC   = 0;
  localparam int FIELD_MIN   = 1;
  localparam int FIELD_HOUR  = 2;
  localparam int FIELD_DAY   = 3;
  localparam int FIELD_MONTH = 4;
  localparam int FIELD_YEAR  = 5;

  localparam int BTN_EDIT = 0;
  localparam int BTN_NEXT = 1;
  localparam int BTN_UP   = 2;
  localparam int BTN_DOWN = 3;
  localparam int BTN_SAVE = 4;
  localparam int NUM_BTNS = 5;
endpackage

// File: rtl/edit_field_sequencer_if.sv
// Button inputs and field-control outputs of the edit sequencer.
// master = button/display side, slave = sequencer.
interface edit_field_sequencer_if #(
  parameter int NUM_FIELDS = edit_field_sequencer_pkg::NUM_FIELDS_DEF
);
  import edit_field_sequencer_pkg::*;

  logic                  btn_edit;
  logic                  btn_next;
  logic                  btn_up;
  logic                  btn_down;
  logic                  btn_save;
  logic [NUM_FIELDS-1:0] field_en;
  logic                  up_o;
  logic                  down_o;
  logic [SEL_W-1:0]      field_sel;
  logic                  edit_active;
  logic                  blink;
  logic                  save_strobe;
  logic                  abort_strobe;

  modport master (
    output btn_edit, btn_next, btn_up, btn_down, btn_save,
    input  field_en, up_o, down_o, field_sel,
    input  edit_active, blink, save_strobe, abort_strobe
  );

  modport slave (
    input  btn_edit, btn_next, btn_up, btn_down, btn_save,
    output field_en, up_o, down_o, field_sel,
    output edit_active, blink, save_strobe, abort_strobe
  );
endinterface

// File: rtl/edit_field_sequencer_edge_pulse.sv
// Rising-edge detector for one debounced button level.
// First cycle after reset only primes history, so held buttons stay silent.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic pulse_o
);
  logic prev_q;
  logic arm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      prev_q <= level_i;
      arm_q  <= 1'b1;
    end
  end

  assign pulse_o = arm_q & level_i & ~prev_q;
endmodule

// File: rtl/edit_field_sequencer.sv
// Button-driven field editor: selects a field, steps it, commits or aborts.
// All outputs come straight from registers.
module edit_field_sequencer
  import edit_field_sequencer_pkg::*;
#(
  parameter int NUM_FIELDS  = NUM_FIELDS_DEF,
  parameter int BLINK_DIV   = 25000000,
  parameter int TIMEOUT_CYC = 500000000
) (
  input  logic                   clk,
  input  logic                   rst,
  edit_field_sequencer_if.slave  bus
);
  localparam int TW =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BW =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [NUM_BTNS-1:0] lvl;
  logic [NUM_BTNS-1:0] ev;

  assign lvl[BTN_EDIT] = bus.btn_edit;
  assign lvl[BTN_NEXT] = bus.btn_next;
  assign lvl[BTN_UP]   = bus.btn_up;
  assign lvl[BTN_DOWN] = bus.btn_down;
  assign lvl[BTN_SAVE] = bus.btn_save;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_edge
    edge_pulse u_edge (
      .clk     (clk),
      .rst     (rst),
      .level_i (lvl[g]),
      .pulse_o (ev[g])
    );
  end

  state_e                state_q;
  logic [SEL_W-1:0]      sel_q;
  logic [NUM_FIELDS-1:0] en_q;
  logic                  up_q;
  logic                  dn_q;
  logic                  act_q;
  logic                  blink_q;
  logic                  save_q;
  logic                  abort_q;
  logic [TW-1:0]         tmo_q;
  logic [BW-1:0]         bcnt_q;

  logic [SEL_W-1:0] sel_d;
  logic             step_ev;
  logic             tmo_hit;

  assign sel_d = (sel_q == SEL_W'(NUM_FIELDS-1))
               ? '0 : sel_q + 1'b1;
  // Simultaneous up and down cancel each other out.
  assign step_ev = ev[BTN_UP] ^ ev[BTN_DOWN];
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      en_q    <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      act_q   <= 1'b0;
      blink_q <= 1'b0;
      save_q  <= 1'b0;
      abort_q <= 1'b0;
      tmo_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      save_q  <= 1'b0;
      abort_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (ev[BTN_EDIT]) begin
            state_q <= S_EDIT;
            sel_q   <= '0;
            en_q    <= NUM_FIELDS'(1);
            act_q   <= 1'b1;
            blink_q <= 1'b1;
            tmo_q   <= '0;
            bcnt_q  <= '0;
          end
        end
        S_EDIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (bcnt_q == BW'(BLINK_DIV-1)) begin
            bcnt_q  <= '0;
            blink_q <= ~blink_q;
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
          end
          if (ev[BTN_SAVE]) begin
            state_q <= S_COMMIT;
            save_q  <= 1'b1;
            en_q    <= '0;
            act_q   <= 1'b0;
            blink_q <= 1'b0;
          end else if (ev[BTN_EDIT] ||
                       (!ev[BTN_NEXT] && !step_ev && tmo_hit)) begin
            state_q <= S_IDLE;
            abort_q <= 1'b1;
            en_q    <= '0;
            act_q   <= 1'b0;
            blink_q <= 1'b0;
          end else if (ev[BTN_NEXT]) begin
            sel_q   <= sel_d;
            en_q    <= NUM_FIELDS'(1) << sel_d;
            blink_q <= 1'b1;
            bcnt_q  <= '0;
            tmo_q   <= '0;
          end else if (step_ev) begin
            up_q  <= ev[BTN_UP];
            dn_q  <= ev[BTN_DOWN];
            tmo_q <= '0;
          end
        end
        S_COMMIT: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.field_en     = en_q;
  assign bus.up_o         = up_q;
  assign bus.down_o       = dn_q;
  assign bus.field_sel    = sel_q;
  assign bus.edit_active  = act_q;
  assign bus.blink        = blink_q;
  assign bus.save_strobe  = save_q;
  assign bus.abort_strobe = abort_q;
endmodule

// File: tb/tb_edit_field_sequencer.sv
// Self-checking bench for edit_field_sequencer against a behavioural model.
// Model counts elapsed/idle cycles directly; blink derives from elapsed time.
module tb_edit_field_sequencer;
  localparam int NF = 6;
  localparam int BD = 4;
  localparam int TO = 20;

  localparam logic [4:0] B_EDIT = 5'b00001;
  localparam logic [4:0] B_NEXT = 5'b00010;
  localparam logic [4:0] B_UP   = 5'b00100;
  localparam logic [4:0] B_DOWN = 5'b01000;
  localparam logic [4:0] B_SAVE = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edit_field_sequencer_if #(.NUM_FIELDS(NF)) ifc ();

  assign ifc.btn_edit = btn[0];
  assign ifc.btn_next = btn[1];
  assign ifc.btn_up   = btn[2];
  assign ifc.btn_down = btn[3];
  assign ifc.btn_save = btn[4];

  edit_field_sequencer #(
    .NUM_FIELDS  (NF),
    .BLINK_DIV   (BD),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // mode: 0 idle, 1 edit, 2 commit
  int         m_mode = 0;
  int         m_sel = 0;
  int         m_idle = 0;
  int         m_since = 0;
  logic [4:0] m_prev = '0;
  bit         m_arm = 0;
  bit         e_up = 0, e_dn = 0, e_save = 0, e_abort = 0;

  always @(posedge clk) begin : model
    logic [4:0] ev;
    if (rst) begin
      m_mode = 0; m_sel = 0; m_idle = 0; m_since = 0;
      m_prev = '0; m_arm = 0;
      e_up = 0; e_dn = 0; e_save = 0; e_abort = 0;
    end else begin
      ev = m_arm ? (btn & ~m_prev) : 5'b0;
      m_prev = btn;
      m_arm = 1;
      e_up = 0; e_dn = 0; e_save = 0; e_abort = 0;
      m_since++;
      if (m_mode == 0) begin
        if (ev[0]) begin
          m_mode = 1; m_sel = 0; m_idle = 0; m_since = 0;
        end
      end else if (m_mode == 2) begin
        m_mode = 0;
      end else begin
        if (ev[4]) begin
          m_mode = 2; e_save = 1;
        end else if (ev[0]) begin
          m_mode = 0; e_abort = 1;
        end else if (ev[1]) begin
          m_sel = (m_sel + 1) % NF; m_idle = 0; m_since = 0;
        end else if (ev[2] != ev[3]) begin
          e_up = ev[2]; e_dn = ev[3]; m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == TO) begin
            m_mode = 0; e_abort = 1;
          end
        end
      end
    end
  end

  function automatic logic [14:0] exp_vec();
    logic [5:0] en;
    logic       bl;
    en = (m_mode == 1) ? 6'(1 << m_sel) : 6'b0;
    bl = (m_mode == 1) && (((m_since / BD) % 2) == 0);
    return {m_mode == 1, 3'(m_sel), en,
            e_up, e_dn, bl, e_save, e_abort};
  endfunction

  function automatic logic [14:0] obs();
    return {ifc.edit_active, ifc.field_sel, ifc.field_en,
            ifc.up_o, ifc.down_o, ifc.blink,
            ifc.save_strobe, ifc.abort_strobe};
  endfunction

  task automatic cyc(input logic [4:0] b);
    btn = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(5'($urandom));
      checks++;
      if (obs() !== 15'b0) begin
        errors++;
        $display("FAIL reset_zero: got %b want 0", obs());
      end
    end
    btn = 5'b11111;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(5'b11111);
      checks++;
      if (obs() !== exp_vec() || ifc.edit_active !== 1'b0) begin
        errors++;
        $display("FAIL reset_held_btn: got %b want %b",
                 obs(), exp_vec());
      end
    end
    cyc(5'b0);
  endtask

  task automatic test_enter();
    cyc(B_EDIT);
    checks++;
    if (ifc.edit_active !== 1'b1 || ifc.field_sel !== 3'd0 ||
        ifc.field_en !== 6'b000001 || ifc.blink !== 1'b1) begin
      errors++;
      $display("FAIL enter: act=%b sel=%0d en=%b blink=%b",
               ifc.edit_active, ifc.field_sel,
               ifc.field_en, ifc.blink);
    end
    cyc(5'b0);
    checks++;
    if (obs() !== exp_vec()) begin
      errors++;
      $display("FAIL enter_model: got %b want %b", obs(), exp_vec());
    end
  endtask

  task automatic test_next();
    for (int i = 1; i <= 6; i++) begin
      cyc(B_NEXT);
      checks++;
      if (ifc.field_sel !== 3'(i % 6) || ifc.blink !== 1'b1 ||
          ifc.field_en !== 6'(1 << (i % 6))) begin
        errors++;
        $display("FAIL next_%0d: sel=%0d en=%b blink=%b", i,
                 ifc.field_sel, ifc.field_en, ifc.blink);
      end
      cyc(5'b0);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL next_model: got %b want %b", obs(), exp_vec());
      end
    end
  endtask

  task automatic test_step();
    int ups;
    int steps;
    for (int i = 0; i < 2; i++) begin
      cyc(B_NEXT);
      cyc(5'b0);
    end
    ups = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(B_UP);
      if (ifc.up_o === 1'b1) begin
        ups++;
        checks++;
        if (ifc.field_en !== 6'b000100 || ifc.down_o !== 1'b0) begin
          errors++;
          $display("FAIL step_up_en: en=%b down=%b",
                   ifc.field_en, ifc.down_o);
        end
      end
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL step_model: got %b want %b", obs(), exp_vec());
      end
    end
    checks++;
    if (ups !== 1) begin
      errors++;
      $display("FAIL step_up_count: got %0d want 1", ups);
    end
    cyc(5'b0);
    steps = 0;
    for (int i = 0; i < 3; i++) begin
      cyc((i < 2) ? (B_UP | B_DOWN) : 5'b0);
      if (ifc.up_o === 1'b1 || ifc.down_o === 1'b1) steps++;
    end
    checks++;
    if (steps !== 0) begin
      errors++;
      $display("FAIL step_both: got %0d steps want 0", steps);
    end
    cyc(B_DOWN);
    checks++;
    if (ifc.down_o !== 1'b1 || ifc.up_o !== 1'b0 ||
        obs() !== exp_vec()) begin
      errors++;
      $display("FAIL step_down: got %b want %b", obs(), exp_vec());
    end
    cyc(5'b0);
  endtask

  task automatic test_save_priority();
    cyc(B_SAVE | B_NEXT);
    checks++;
    if (ifc.save_strobe !== 1'b1 || ifc.field_sel !== 3'd2 ||
        ifc.field_en !== 6'b0) begin
      errors++;
      $display("FAIL save_strobe: save=%b sel=%0d en=%b",
               ifc.save_strobe, ifc.field_sel, ifc.field_en);
    end
    cyc(5'b0);
    checks++;
    if (ifc.save_strobe !== 1'b0 || ifc.edit_active !== 1'b0 ||
        ifc.field_sel !== 3'd2 || ifc.field_en !== 6'b0 ||
        obs() !== exp_vec()) begin
      errors++;
      $display("FAIL save_idle: got %b want %b", obs(), exp_vec());
    end
  endtask

  task automatic test_timeout();
    int hit;
    cyc(B_EDIT);
    hit = -1;
    for (int k = 1; k <= 24; k++) begin
      cyc(5'b0);
      if (ifc.abort_strobe === 1'b1) hit = k;
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL timeout_model k=%0d: got %b want %b",
                 k, obs(), exp_vec());
      end
    end
    checks++;
    if (hit !== TO || ifc.edit_active !== 1'b0) begin
      errors++;
      $display("FAIL timeout_cycle: got %0d want %0d", hit, TO);
    end
  endtask

  task automatic test_reset_mid();
    cyc(B_EDIT);
    cyc(B_NEXT);
    cyc(B_UP);
    rst = 1'b1;
    cyc(5'b0);
    checks++;
    if (obs() !== 15'b0) begin
      errors++;
      $display("FAIL reset_mid_edit: got %b want 0", obs());
    end
    rst = 1'b0;
    cyc(5'b0);
    cyc(B_EDIT);
    cyc(B_SAVE);
    rst = 1'b1;
    cyc(5'b0);
    checks++;
    if (obs() !== 15'b0) begin
      errors++;
      $display("FAIL reset_mid_commit: got %b want 0", obs());
    end
    rst = 1'b0;
    cyc(5'b0);
  endtask

  task automatic test_random();
    logic [4:0] b;
    int quiet;
    b = '0;
    quiet = 0;
    for (int n = 0; n < 1500; n++) begin
      if (quiet > 0) begin
        quiet--;
      end else begin
        if ($urandom_range(0, 99) < 4)  b[0] = ~b[0];
        for (int j = 1; j < 5; j++)
          if ($urandom_range(0, 99) < 15) b[j] = ~b[j];
        if ($urandom_range(0, 99) < 3) quiet = 25;
      end
      rst = ($urandom_range(0, 299) == 0);
      cyc(b);
      checks++;
      if (obs() !== exp_vec() ||
          (ifc.up_o === 1'b1 && ifc.down_o === 1'b1)) begin
        errors++;
        $display("FAIL random n=%0d: got %b want %b",
                 n, obs(), exp_vec());
      end
    end
    rst = 1'b0;
    cyc(5'b0);
  endtask

  initial begin
    test_reset();
    test_enter();
    test_next();
    test_step();
    test_save_priority();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
